// File: rtl/llc_plru_tracker_pkg.sv
// Shared definitions for the LLC pseudo-LRU tracker: default geometry,
// request opcode encoding and controller states.
package LLC_defs;
  localparam int NUM_SETS      = 16384;
  localparam int ASSOCIATIVITY = 16;
  localparam int P_LRU         = ASSOCIATIVITY - 1;

  typedef enum logic [1:0] {
    OP_TOUCH  = 2'b00,
    OP_VICTIM = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/llc_plru_tracker_tree.sv
// Combinational tree-PLRU update for one set: victim walk, touch, clear.
// LLC_PLRU_INVALID_FIRST_EN adds invalid-way-first victim selection.
module llc_plru_tree
  import LLC_defs::*;
#(
  parameter int WAYS = ASSOCIATIVITY,
  localparam int TW = WAYS - 1,
  localparam int WW = $clog2(WAYS)
)(
  input  logic [TW-1:0]   bits,
  input  op_e             op,
  input  logic [WW-1:0]   way,
`ifdef LLC_PLRU_INVALID_FIRST_EN
  input  logic [WAYS-1:0] valid_mask,
`endif
  output logic [TW-1:0]   new_bits,
  output logic [WW-1:0]   sel_way
);
  logic [WW-1:0] walk_way, tgt;
  int n;

  always_comb begin
    walk_way = '0;
    tgt      = way;
    new_bits = bits;
    sel_way  = way;
    n        = 0;
    // node n's bit picks child 2n+1 (0) or 2n+2 (1); leaves sit at TW..2*TW
    for (int l = 0; l < WW; l++) n = 2 * n + 1 + int'(bits[n]);
    walk_way = WW'(n - TW);
`ifdef LLC_PLRU_INVALID_FIRST_EN
    for (int i = WAYS - 1; i >= 0; i--)
      if (!valid_mask[i]) walk_way = WW'(i);
`endif
    if (op == OP_VICTIM) tgt = walk_way;
    n = 0;
    for (int l = 0; l < WW; l++) begin
      new_bits[n] = ~tgt[WW-1-l];
      n = 2 * n + 1 + int'(tgt[WW-1-l]);
    end
    sel_way = tgt;
    if (op == OP_CLEAR) begin
      new_bits = '0;
      sel_way  = '0;
    end
  end
endmodule

// File: rtl/llc_plru_tracker.sv
// Per-set tree-PLRU state tracker: init sweep, then a 2-stage read/modify/write
// pipeline with same-set forwarding. LLC_PLRU_INVALID_FIRST_EN adds valid_mask.
module llc_plru_tracker #(
  parameter int NUM_SETS = LLC_defs::NUM_SETS,
  parameter int WAYS     = LLC_defs::ASSOCIATIVITY,
  localparam int IW = $clog2(NUM_SETS),
  localparam int WW = $clog2(WAYS),
  localparam int TW = WAYS - 1
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [IW-1:0]   req_index,
  input  logic [WW-1:0]   req_way,
`ifdef LLC_PLRU_INVALID_FIRST_EN
  input  logic [WAYS-1:0] valid_mask,
`endif
  output logic            rsp_valid,
  output logic [WW-1:0]   rsp_way,
  output logic            init_done
);
  localparam int STAGES = 2;

  LLC_defs::state_e state, state_nxt;
  logic [IW-1:0] sweep, sweep_nxt;
  logic          sweep_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LLC_defs::ST_INIT;
      sweep <= '0;
    end else begin
      state <= state_nxt;
      sweep <= sweep_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep;
    sweep_we  = 1'b0;
    case (state)
      LLC_defs::ST_INIT: begin
        sweep_we  = 1'b1;
        sweep_nxt = sweep + 1'b1;
        if (sweep == IW'(NUM_SETS - 1)) state_nxt = LLC_defs::ST_RUN;
      end
      default: ;
    endcase
  end

  assign req_ready = (state == LLC_defs::ST_RUN);
  assign init_done = (state == LLC_defs::ST_RUN);

  logic [STAGES:0]  vld_pipe;
  LLC_defs::op_e    s1_op, s2_op;
  logic [IW-1:0]    s1_idx, s2_idx;
  logic [WW-1:0]    s1_way, s2_way, tree_way;
  logic [TW-1:0]    s2_bits, rd_bits, new_bits;
  logic [TW-1:0]    mem [NUM_SETS];
  logic             accept;
`ifdef LLC_PLRU_INVALID_FIRST_EN
  logic [WAYS-1:0]  s1_mask, s2_mask;
`endif

  // reserved opcodes are swallowed at the door: no state change, no response
  assign accept  = req_valid && req_ready && (LLC_defs::op_e'(req_op) != LLC_defs::OP_RSVD);
  assign rd_bits = (vld_pipe[1] && s2_idx == s1_idx) ? new_bits : mem[s1_idx];
  assign rsp_valid = vld_pipe[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      rsp_way  <= '0;
      s1_op    <= LLC_defs::OP_TOUCH;
      s1_idx   <= '0;
      s1_way   <= '0;
      s2_op    <= LLC_defs::OP_TOUCH;
      s2_idx   <= '0;
      s2_way   <= '0;
      s2_bits  <= '0;
`ifdef LLC_PLRU_INVALID_FIRST_EN
      s1_mask  <= '0;
      s2_mask  <= '0;
`endif
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], accept};
      if (accept) begin
        s1_op  <= LLC_defs::op_e'(req_op);
        s1_idx <= req_index;
        s1_way <= req_way;
`ifdef LLC_PLRU_INVALID_FIRST_EN
        s1_mask <= valid_mask;
`endif
      end
      if (vld_pipe[0]) begin
        s2_op   <= s1_op;
        s2_idx  <= s1_idx;
        s2_way  <= s1_way;
        s2_bits <= rd_bits;
`ifdef LLC_PLRU_INVALID_FIRST_EN
        s2_mask <= s1_mask;
`endif
      end
      if (vld_pipe[1]) rsp_way <= tree_way;
    end
  end

  // state array carries no reset; the INIT sweep clears it
  always_ff @(posedge clk) begin
    if (sweep_we)         mem[sweep]  <= '0;
    else if (vld_pipe[1]) mem[s2_idx] <= new_bits;
  end

  llc_plru_tree #(.WAYS(WAYS)) u_tree (
    .bits       (s2_bits),
    .op         (s2_op),
    .way        (s2_way),
`ifdef LLC_PLRU_INVALID_FIRST_EN
    .valid_mask (s2_mask),
`endif
    .new_bits   (new_bits),
    .sel_way    (tree_way)
  );
endmodule

// File: tb/tb_llc_plru_tracker.sv
// Directed scoreboard bench for llc_plru_tracker (NUM_SETS=8, WAYS=4).
module tb_llc_plru_tracker;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [2:0] req_index = '0;
  logic [1:0] req_way = '0;
  logic [3:0] mask = 4'hF;
  logic       rsp_valid;
  logic [1:0] rsp_way;
  logic       init_done;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rsp = 0;
  int r0;
  int exp_q[$];

  always #5 clk = ~clk;

  llc_plru_tracker #(.NUM_SETS(8), .WAYS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_index  (req_index),
    .req_way    (req_way),
`ifdef LLC_PLRU_INVALID_FIRST_EN
    .valid_mask (mask),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_way    (rsp_way),
    .init_done  (init_done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // scoreboard: each response pops the oldest expected way
  always @(negedge clk) begin
    if (rsp_valid) begin
      n_rsp++;
      chk("rsp_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("rsp_way", int'(rsp_way), exp_q.pop_front());
    end
  end

  task automatic send(input logic [1:0] op, input int idx, input int way,
                      input logic [3:0] m, input bit push, input int exp);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_index = 3'(idx);
    req_way   = 2'(way);
    mask      = m;
    if (push) exp_q.push_back(exp);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic init_check(input string tag);
    for (int k = 0; k < 8; k++) begin
      chk({tag, "_init_low"}, int'(init_done), 0);
      chk({tag, "_ready_low"}, int'(req_ready), 0);
      @(negedge clk);
    end
    chk({tag, "_init_high"}, int'(init_done), 1);
    chk({tag, "_ready_high"}, int'(req_ready), 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_way", int'(rsp_way), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_init_done", int'(init_done), 0);
    rst = 1'b0;
    init_check("boot");

    // back-to-back victims on one set rely on stage-2 forwarding
    send(2'b01, 3, 0, 4'hF, 1, 0);
    send(2'b01, 3, 0, 4'hF, 1, 2);
    send(2'b01, 3, 0, 4'hF, 1, 1);
    send(2'b01, 3, 0, 4'hF, 1, 3);
    idle();
    drain();

    send(2'b00, 5, 3, 4'hF, 1, 3);
    send(2'b01, 5, 0, 4'hF, 1, 0);
    send(2'b10, 5, 2, 4'hF, 1, 0);
    send(2'b01, 5, 0, 4'hF, 1, 0);
    idle();
    drain();

    // reserved op must not touch way 2 nor respond
    send(2'b00, 6, 0, 4'hF, 1, 0);
    send(2'b11, 6, 2, 4'hF, 0, 0);
    send(2'b01, 6, 0, 4'hF, 1, 2);
    idle();
    drain();

`ifdef LLC_PLRU_INVALID_FIRST_EN
    send(2'b00, 1, 0, 4'hF, 1, 0);
    send(2'b01, 1, 0, 4'b1011, 1, 2);
    send(2'b01, 1, 0, 4'hF, 1, 1);
    idle();
    drain();
`endif

    // reset with a victim in flight: no response, array re-cleared
    send(2'b00, 2, 0, 4'hF, 1, 0);
    idle();
    drain();
    r0 = n_rsp;
    send(2'b01, 2, 0, 4'hF, 0, 0);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_inflight_dropped", n_rsp - r0, 0);
    rst = 1'b0;
    init_check("rerun");
    send(2'b01, 2, 0, 4'hF, 1, 0);
    idle();
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
